// File: rtl/multiple_byte_receiver_if.sv
// Result/serial bundle for multiple_byte_receiver.
//   uart_input              : raw serial line into the receiver (idle high)
//   data_out                : last completed frame payload, little endian
//   number_of_bits_received : payload length in bits (N*8)
//   data_valid              : one-cycle pulse, data_out/number_of_bits_received updated
//   frame_error             : one-cycle pulse, frame aborted
// Modports: master = receiver side, slave = line driver / result consumer.
interface multiple_byte_receiver_if #(
  parameter int unsigned MAX_BITS_TO_RECEIVE = 128
);
  localparam int unsigned NB_W = $clog2(MAX_BITS_TO_RECEIVE + 1);

  logic                           uart_input;
  logic [MAX_BITS_TO_RECEIVE-1:0] data_out;
  logic [NB_W-1:0]                number_of_bits_received;
  logic                           data_valid;
  logic                           frame_error;

  modport master (
    input  uart_input,
    output data_out, number_of_bits_received, data_valid, frame_error
  );

  modport slave (
    output uart_input,
    input  data_out, number_of_bits_received, data_valid, frame_error
  );
endinterface

// File: rtl/multiple_byte_receiver.sv
// Multi-byte UART frame receiver: 8N1 bit reception from the raw line, then
// framing of <length N><N payload bytes, LSB first> into one word.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : multiple_byte_receiver_if.master (uart_input in; data_out,
//           number_of_bits_received, data_valid, frame_error out)
// Optional: define MULTIPLE_BYTE_RECEIVER_TIMEOUT_EN to abort a frame after
// FRAME_TIMEOUT_CLKS idle clocks between bytes.
module multiple_byte_receiver #(
  parameter int unsigned CLKS_PER_BIT        = 10416,
  parameter int unsigned MAX_BITS_TO_RECEIVE = 128,
  parameter int unsigned FRAME_TIMEOUT_CLKS  = 20 * CLKS_PER_BIT
) (
  input  logic                     clk,
  input  logic                     reset,
  multiple_byte_receiver_if.master bus
);
  localparam int unsigned MAX_BYTES = (MAX_BITS_TO_RECEIVE + 7) / 8;
  localparam int unsigned ACC_W     = MAX_BYTES * 8;
  localparam int unsigned NB_W      = $clog2(MAX_BITS_TO_RECEIVE + 1);
  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4 || MAX_BITS_TO_RECEIVE < 8 || MAX_BYTES > 255 ||
      FRAME_TIMEOUT_CLKS < 1) begin : g_param_check
    $error("multiple_byte_receiver: unsupported parameter set");
  end

  // ---------------------------------------------------------------- sync
  logic r_sync1, r_sync2;
  logic w_rx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.uart_input;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  // -------------------------------------------------------- bit receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_stop_bad;   // stop bit was low: wait for line high
  logic             r_byte_done;
  logic             r_byte_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state  <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_stop_bad  <= 1'b0;
      r_byte_done <= 1'b0;
      r_byte_err  <= 1'b0;
    end else begin
      r_byte_done <= 1'b0;
      r_byte_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt  <= '0;
          r_stop_bad <= 1'b0;
          if (!w_rx) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_M1) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_stop_bad) begin
            if (w_rx) r_rx_state <= RX_IDLE;
          end else if (r_clk_cnt == FULL_M1) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_byte_done <= 1'b1;
              r_rx_state  <= RX_IDLE;
            end else begin
              r_byte_err <= 1'b1;
              r_stop_bad <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- frame FSM
  typedef enum logic [1:0] {WAIT_LENGTH, RECEIVING_DATA, DISCARDING} frame_state_t;

  frame_state_t     r_fr_state;
  logic [7:0]       r_len;        // frame length, or bytes left while discarding
  logic [7:0]       r_idx;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_len_fits;
  logic             w_last_byte;
  logic             w_timeout;

  // Accumulator with the current byte merged in, so the last byte can be
  // published in the same edge that stores it.
  always_comb begin
    w_acc_next = r_acc;
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (32'(r_idx) == b) w_acc_next[b*8 +: 8] = r_shift;
    end
  end

  assign w_len_fits  = (32'(r_shift) <= MAX_BYTES);
  assign w_last_byte = (r_idx == r_len - 8'd1);

`ifdef MULTIPLE_BYTE_RECEIVER_TIMEOUT_EN
  logic [31:0] r_idle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_cnt <= '0;
    end else if (r_fr_state == WAIT_LENGTH || r_byte_done || r_rx_state != RX_IDLE) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end
  end

  assign w_timeout = (r_fr_state != WAIT_LENGTH) && (r_rx_state == RX_IDLE) &&
                     !r_byte_done && (r_idle_cnt == FRAME_TIMEOUT_CLKS - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fr_state                  <= WAIT_LENGTH;
      r_len                       <= '0;
      r_idx                       <= '0;
      r_acc                       <= '0;
      bus.data_out                <= '0;
      bus.number_of_bits_received <= '0;
      bus.data_valid              <= 1'b0;
      bus.frame_error             <= 1'b0;
    end else begin
      bus.data_valid  <= 1'b0;
      bus.frame_error <= 1'b0;
      if (r_byte_err || w_timeout) begin
        bus.frame_error <= 1'b1;
        r_fr_state      <= WAIT_LENGTH;
      end else if (r_byte_done) begin
        case (r_fr_state)
          WAIT_LENGTH: begin
            if (r_shift != 8'd0) begin
              r_len <= r_shift;
              if (w_len_fits) begin
                r_idx      <= '0;
                r_acc      <= '0;
                r_fr_state <= RECEIVING_DATA;
              end else begin
                r_fr_state <= DISCARDING;
              end
            end
          end
          RECEIVING_DATA: begin
            r_acc <= w_acc_next;
            if (w_last_byte) begin
              bus.data_out                <= w_acc_next[MAX_BITS_TO_RECEIVE-1:0];
              bus.number_of_bits_received <= NB_W'(32'(r_len) << 3);
              bus.data_valid              <= 1'b1;
              r_fr_state                  <= WAIT_LENGTH;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
          DISCARDING: begin
            r_len <= r_len - 8'd1;
            if (r_len == 8'd1) begin
              bus.frame_error <= 1'b1;
              r_fr_state      <= WAIT_LENGTH;
            end
          end
          default: r_fr_state <= WAIT_LENGTH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_multiple_byte_receiver.sv
module tb_multiple_byte_receiver;
  localparam int unsigned CPB = 16;
  localparam int unsigned MB  = 32;
  localparam int unsigned MAXB = MB / 8;
  localparam int unsigned TO  = 400;
  localparam int unsigned NBW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;

  multiple_byte_receiver_if #(.MAX_BITS_TO_RECEIVE(MB)) bus ();

  multiple_byte_receiver #(
    .CLKS_PER_BIT(CPB),
    .MAX_BITS_TO_RECEIVE(MB),
    .FRAME_TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Pulse monitor, sampled on the falling edge.
  int n_valid = 0, n_err = 0, n_both = 0;
  longint cyc = 0, last_valid_cyc = 0, last_err_cyc = 0, stop_start_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.data_valid) begin n_valid++; last_valid_cyc = cyc; end
    if (bus.frame_error) begin n_err++; last_err_cyc = cyc; end
    if (bus.data_valid && bus.frame_error) n_both++;
  end

  // Reference model: what the last good frame left on the outputs.
  logic [MB-1:0]  exp_data = '0;
  logic [NBW-1:0] exp_bits = '0;
  byte unsigned   q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MB-1:0] word_of(input byte unsigned pl[$]);
    logic [MB-1:0] w;
    w = '0;
    foreach (pl[i]) w = w | (MB'(pl[i]) << (8 * i));
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    logic [9:0] f;
    f = {good_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (i == 9) stop_start_cyc = cyc;
      bus.uart_input = f[i];
      repeat (CPB) @(negedge clk);
    end
    bus.uart_input = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.uart_input = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Sends <len><pl...> with no idle gaps and checks the outcome from the
  // framing rules alone.
  task automatic do_frame(input string tag, input byte unsigned len, input byte unsigned pl[$]);
    int  v0, e0;
    bit  ok;
    v0 = n_valid;
    e0 = n_err;
    send_byte(len, 1'b1);
    foreach (pl[i]) send_byte(pl[i], 1'b1);
    ok = (len >= 1) && (len <= MAXB);
    if (ok) begin
      exp_data = word_of(pl);
      exp_bits = NBW'(len * 8);
    end
    check({tag, ".valid_cnt"}, 64'(n_valid - v0), ok ? 64'd1 : 64'd0);
    check({tag, ".err_cnt"}, 64'(n_err - e0), (len > MAXB) ? 64'd1 : 64'd0);
    check({tag, ".data"}, 64'(bus.data_out), 64'(exp_data));
    check({tag, ".bits"}, 64'(bus.number_of_bits_received), 64'(exp_bits));
    if (ok)
      check({tag, ".latency"}, 64'((last_valid_cyc > stop_start_cyc) &&
                                   (last_valid_cyc < stop_start_cyc + CPB)), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    byte unsigned len;

    bus.uart_input = 1'b1;
    repeat (5) @(negedge clk);
    check("rst.data", 64'(bus.data_out), 64'd0);
    check("rst.bits", 64'(bus.number_of_bits_received), 64'd0);
    check("rst.valid", 64'(bus.data_valid), 64'd0);
    check("rst.err", 64'(bus.frame_error), 64'd0);
    reset = 1'b1;
    idle(20);

    q = '{8'h34, 8'h12};
    do_frame("f1234", 8'h02, q);

    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_frame("f4", 8'h04, q);
    q = '{8'h5A};
    do_frame("f5a", 8'h01, q);

    q = {};
    do_frame("zero_len", 8'h00, q);
    q = '{8'h77};
    do_frame("f77", 8'h01, q);

    q = {};
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    do_frame("too_long", 8'h06, q);
    q = '{8'h11};
    do_frame("f11", 8'h01, q);

    // Bad stop bit on the first payload byte.
    v0 = n_valid; e0 = n_err;
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b0);
    idle(3 * CPB);
    check("badstop.valid_cnt", 64'(n_valid - v0), 64'd0);
    check("badstop.err_cnt", 64'(n_err - e0), 64'd1);
    check("badstop.held", 64'(bus.data_out), 64'(exp_data));

    // Short low glitch on the idle line.
    v0 = n_valid; e0 = n_err;
    bus.uart_input = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    check("glitch.pulses", 64'((n_valid - v0) + (n_err - e0)), 64'd0);

    q = '{8'h99};
    do_frame("f99", 8'h01, q);

    for (int k = 0; k < 8; k++) begin
      len = 8'($urandom_range(0, 6));
      q = {};
      for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
      do_frame("rand", len, q);
    end

`ifdef MULTIPLE_BYTE_RECEIVER_TIMEOUT_EN
    v0 = n_valid; e0 = n_err;
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(500);
    check("timeout.err_cnt", 64'(n_err - e0), 64'd1);
    check("timeout.valid_cnt", 64'(n_valid - v0), 64'd0);
    check("timeout.when", 64'((last_err_cyc - stop_start_cyc >= TO) &&
                             (last_err_cyc - stop_start_cyc <= TO + 20)), 64'd1);
    check("timeout.held", 64'(bus.data_out), 64'(exp_data));
`else
    // Without the timeout a long gap inside a frame is tolerated.
    v0 = n_valid; e0 = n_err;
    send_byte(8'h02, 1'b1);
    send_byte(8'h34, 1'b1);
    idle(500);
    send_byte(8'h12, 1'b1);
    check("gap.err_cnt", 64'(n_err - e0), 64'd0);
    check("gap.valid_cnt", 64'(n_valid - v0), 64'd1);
    check("gap.data", 64'(bus.data_out), 64'h1234);
    exp_data = 32'h1234;
    exp_bits = NBW'(16);
`endif

    // Reset in the middle of a frame.
    send_byte(8'h03, 1'b1);
    send_byte(8'h56, 1'b1);
    bus.uart_input = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst.data", 64'(bus.data_out), 64'd0);
    check("midrst.bits", 64'(bus.number_of_bits_received), 64'd0);
    check("midrst.valid", 64'(bus.data_valid), 64'd0);
    check("midrst.err", 64'(bus.frame_error), 64'd0);
    exp_data = '0;
    exp_bits = '0;
    bus.uart_input = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle(2 * CPB);
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_frame("post_rst", 8'h03, q);

    check("never_both", 64'(n_both), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multiple_byte_receiver.md
Name: multiple_byte_receiver

Overview:
- Receive-side counterpart of the multi-byte UART framing: frame = one length byte N, then N payload bytes, least-significant byte first.
- Does its own 8N1 bit-level reception from the raw serial line.
- Reassembles each frame into one word and presents it with a single-cycle valid pulse.
- Sits between the board UART RX pin and result/command consumers.

Parameters:
- CLKS_PER_BIT, 10416: clocks per UART bit.
- MAX_BITS_TO_RECEIVE, 128: width of the reassembled word. MAX_BYTES = (MAX_BITS_TO_RECEIVE+7)/8.
- FRAME_TIMEOUT_CLKS, 20*CLKS_PER_BIT: inter-byte idle limit inside a frame. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- uart_input  in  1  raw serial line; idle high.
- data_out  out  MAX_BITS_TO_RECEIVE  last completed frame payload, little endian, unused upper bytes zero.
- number_of_bits_received  out  $clog2(MAX_BITS_TO_RECEIVE+1)  payload length in bits = N*8.
- data_valid  out  1  one-cycle pulse: data_out and number_of_bits_received just updated.
- frame_error  out  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (async assert, sync-safe release):
  - All outputs 0.
  - Bit receiver to RX_IDLE; frame FSM to WAIT_LENGTH.
  - Synchronizer flops preset to 1.
- Reset mid-frame discards all partial state.
- Input path: 2-flop synchronizer on uart_input; all logic uses the synchronized value.

Bit receiver, states RX_IDLE, RX_START, RX_DATA, RX_STOP:
- RX_IDLE: synchronized line low -> RX_START, counter cleared.
- RX_START: at CLKS_PER_BIT/2, line still low -> RX_DATA; line high -> RX_IDLE (glitch, nothing reported).
- RX_DATA: 8 samples, one every CLKS_PER_BIT, LSB first.
- RX_STOP: sampled after a further CLKS_PER_BIT.
  - Stop = 1: internal byte_done pulse with the byte.
  - Stop = 0: internal byte_err pulse. Return to RX_IDLE only once the line is high again.

Frame FSM, states WAIT_LENGTH, RECEIVING_DATA, DISCARDING:
- WAIT_LENGTH, byte_done with value L:
  - L = 0: ignore, stay, no output pulse.
  - 1 <= L <= MAX_BYTES: latch L, byte_index = 0, clear accumulator to all zero -> RECEIVING_DATA.
  - L > MAX_BYTES: latch L as remaining count -> DISCARDING.
- RECEIVING_DATA, byte_done:
  - Write byte to accumulator[byte_index*8 +: 8].
  - If byte_index == L-1: on the next edge, load data_out from accumulator including this byte, set number_of_bits_received = L*8, pulse data_valid -> WAIT_LENGTH.
  - Otherwise byte_index increments.
- DISCARDING: count down bytes without storing. The byte that brings the count to 0 -> frame_error pulse -> WAIT_LENGTH.
- byte_err in any state: frame_error pulse -> WAIT_LENGTH, partial frame dropped. data_out unchanged.
- Latency: data_valid rises on the first clk edge after the stop-bit sample of the last payload byte.
- Hold: data_out and number_of_bits_received hold until the next successful frame. They are never changed by errors.
- Simultaneity: data_valid and frame_error are never asserted in the same cycle.
- Back-to-back frames with zero idle between the stop bit and the next start bit are accepted.
- Width rule: L*8 computed at output width. L <= MAX_BYTES guarantees no overflow.

Optional Feature:
- Macro: MULTIPLE_BYTE_RECEIVER_TIMEOUT_EN.
- Defined:
  - In RECEIVING_DATA or DISCARDING, an idle counter counts clocks since the last byte_done.
  - The counter is reset by each byte_done and held at 0 while the bit receiver is not in RX_IDLE.
  - Reaching FRAME_TIMEOUT_CLKS: frame_error pulse -> WAIT_LENGTH, partial data dropped.
- Undefined: no counter, no timeout; the FSM waits indefinitely for remaining bytes.

Test Plan (CLKS_PER_BIT=16, MAX_BITS_TO_RECEIVE=32):
- Bytes 0x02,0x34,0x12 -> one data_valid pulse, data_out=0x00001234, number_of_bits_received=16, frame_error never high.
- Frame 0x04,AA,BB,CC,DD, then frame 0x01,5A -> first 0xDDCCBBAA/32, then 0x0000005A/8 (upper bytes cleared); exactly two pulses.
- Byte 0x00, then 0x01,77 -> exactly one data_valid, data_out=0x00000077, bits=8.
- Length 0x06 plus six bytes, then 0x01,11 -> frame_error pulse after the 6th byte, no data_valid for it; then data_valid with 0x00000011; previous data_out held meanwhile.
- Frame 0x02,34,12 with stop bit of 0x34 forced low -> frame_error, no data_valid. A 4-clk low glitch on the idle line -> nothing. A following good frame 0x01,99 -> valid 0x99.
- With MULTIPLE_BYTE_RECEIVER_TIMEOUT_EN, FRAME_TIMEOUT_CLKS=400: bytes 0x02,0x34 then idle 500 clks -> frame_error at 400 clks. Separately, reset=0 mid-frame -> all outputs 0 immediately; next frame decodes correctly.
